// File: rtl/updown_bounce_sequencer.sv
// updown_bounce_sequencer: drives an up/down counter through lo->hi->lo bounces for N passes.
// Optional BOUNCE_PAUSE_EN adds a pause input that freezes the sequence.
module updown_bounce_sequencer #(
  parameter int WIDTH = 3,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [PASS_W-1:0] passes,
  input  logic              abort,
`ifdef BOUNCE_PAUSE_EN
  input  logic              pause,
`endif
  input  logic [WIDTH-1:0]  Count,
  output logic              load,
  output logic [WIDTH-1:0]  Data_in,
  output logic              count_up,
  output logic              counter_on,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PASS_W-1:0] pass_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] lo_r, hi_r;
  logic [PASS_W-1:0] passes_r, pass_nxt;
  logic ok, run, viol, at_lo, at_hi, last, pz;
`ifdef BOUNCE_PAUSE_EN
  assign pz = pause;
`else
  assign pz = 1'b0;
`endif
  assign ok = (lo < hi) && (passes != '0);
  assign run = (state == UP) || (state == DOWN);
  assign at_lo = Count == lo_r;
  assign at_hi = Count == hi_r;
  assign viol = run && ((Count < lo_r) || (Count > hi_r));
  assign pass_nxt = pass_cnt + {{(PASS_W-1){1'b0}}, 1'b1};
  assign last = (state == DOWN) && at_lo && (pass_nxt == passes_r);
  assign busy = (state == LOAD) || run;
  always_comb begin
    nxt = state;
    load = 1'b0;
    Data_in = '0;
    count_up = 1'b0;
    counter_on = 1'b0;
    case (state)
      IDLE: nxt = (start && ok) ? LOAD : IDLE;
      LOAD: begin
        load = !abort && !pz;
        Data_in = lo_r;
        nxt = abort ? IDLE : pz ? LOAD : UP;
      end
      UP: begin
        count_up = !at_hi;
        counter_on = !abort && !viol && !pz;
        nxt = (abort || viol) ? IDLE : pz ? UP : at_hi ? DOWN : UP;
      end
      DOWN: begin
        count_up = at_lo;
        counter_on = !abort && !viol && !pz && !last;
        nxt = (abort || viol) ? IDLE : pz ? DOWN : last ? DONE : at_lo ? UP : DOWN;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      lo_r <= '0;
      hi_r <= '0;
      passes_r <= '0;
      pass_cnt <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      done <= nxt == DONE;
      err <= ((state == IDLE) && start && !ok) || (viol && !abort);
      if ((state == IDLE) && start && ok) begin
        lo_r <= lo;
        hi_r <= hi;
        passes_r <= passes;
        pass_cnt <= '0;
      end else if ((state == DOWN) && at_lo && !abort && !viol && !pz)
        pass_cnt <= pass_nxt;
    end
  end
endmodule

// File: tb/tb_updown_bounce_sequencer.sv
// tb_updown_bounce_sequencer: directed bench with a behavioural 3-bit up/down counter attached.
module tb_updown_bounce_sequencer;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, cnt_clr = 1'b1;
  logic [2:0] lo = '0, hi = '0, Count, Data_in;
  logic [3:0] passes = '0, pass_cnt;
  logic load, count_up, counter_on, busy, done, err;
`ifdef BOUNCE_PAUSE_EN
  logic pause = 1'b0;
`endif
  int errors = 0, checks = 0;
  updown_bounce_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .lo(lo), .hi(hi), .passes(passes), .abort(abort),
`ifdef BOUNCE_PAUSE_EN
    .pause(pause),
`endif
    .Count(Count), .load(load), .Data_in(Data_in), .count_up(count_up), .counter_on(counter_on),
    .busy(busy), .done(done), .err(err), .pass_cnt(pass_cnt));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (cnt_clr) Count <= '0;
    else if (load) Count <= Data_in;
    else if (counter_on) Count <= count_up ? Count + 3'd1 : Count - 3'd1;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    int seq [9] = '{1, 2, 3, 2, 1, 2, 3, 2, 1};
    start = 1'b1;
    cyc(); cyc();
    chk("rst_load", load, 0); chk("rst_on", counter_on, 0); chk("rst_up", count_up, 0);
    chk("rst_din", Data_in, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0); chk("rst_pass", pass_cnt, 0);
    start = 1'b0;
    reset = 1'b1;
    cyc(); cnt_clr = 1'b0; cyc();
    chk("idle_busy", busy, 0); chk("idle_load", load, 0);
    lo = 3'd1; hi = 3'd3; passes = 4'd2; start = 1'b1;
    cyc(); start = 1'b0; #1;
    chk("load_load", load, 1); chk("load_din", Data_in, 1); chk("load_on", counter_on, 0); chk("load_busy", busy, 1);
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk($sformatf("run_count%0d", i), Count, seq[i]);
      chk($sformatf("run_busy%0d", i), busy, 1);
    end
    chk("last_on", counter_on, 0);
    cyc();
    chk("done_pulse", done, 1); chk("done_count", Count, 1); chk("done_pass", pass_cnt, 2); chk("done_busy", busy, 0);
    cyc();
    chk("done_end", done, 0); chk("hold_pass", pass_cnt, 2); chk("hold_count", Count, 1);
    lo = 3'd5; hi = 3'd5; passes = 4'd3; start = 1'b1;
    cyc(); start = 1'b0; #1;
    chk("bad1_err", err, 1); chk("bad1_busy", busy, 0); chk("bad1_load", load, 0);
    cyc();
    chk("bad1_end", err, 0);
    lo = 3'd0; hi = 3'd7; passes = 4'd0; start = 1'b1;
    cyc(); start = 1'b0; #1;
    chk("bad2_err", err, 1); chk("bad2_busy", busy, 0);
    lo = 3'd0; hi = 3'd7; passes = 4'd1; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk("abt_pre", Count, 4);
    abort = 1'b1; #1;
    chk("abt_on", counter_on, 0); chk("abt_load", load, 0);
    cyc(); abort = 1'b0; #1;
    chk("abt_count", Count, 4); chk("abt_busy", busy, 0); chk("abt_done", done, 0); chk("abt_err", err, 0);
    lo = 3'd2; hi = 3'd6; passes = 4'd3; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
    chk("vio_pre", Count, 5);
    cnt_clr = 1'b1;
    cyc(); cnt_clr = 1'b0; #1;
    chk("vio_count", Count, 0); chk("vio_on", counter_on, 0); chk("vio_busy_pre", busy, 1);
    cyc();
    chk("vio_err", err, 1); chk("vio_busy", busy, 0); chk("vio_done", done, 0);
    cyc();
    chk("vio_end", err, 0);
    start = 1'b1; lo = 3'd1; hi = 3'd3; passes = 4'd1;
    cyc(); start = 1'b1; #1;
    chk("busy_start_err", err, 0);
    cyc(); start = 1'b0; #1;
    chk("busy_start_err2", err, 0); chk("busy_start_busy", busy, 1);
    abort = 1'b1; cyc(); abort = 1'b0; #1;
    chk("abort2_busy", busy, 0);
`ifdef BOUNCE_PAUSE_EN
    lo = 3'd0; hi = 3'd3; passes = 4'd1; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    chk("pz_pre", Count, 2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("pz_on%0d", i), counter_on, 0);
      cyc();
      chk($sformatf("pz_hold%0d", i), Count, 2);
    end
    pause = 1'b0;
    cyc(); chk("pz_c3", Count, 3);
    cyc(); chk("pz_c2", Count, 2);
    cyc(); chk("pz_c1", Count, 1);
    cyc(); chk("pz_c0", Count, 0); chk("pz_nodone", done, 0);
    cyc(); chk("pz_done", done, 1); chk("pz_pass", pass_cnt, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
